// File: rtl/pe_row_scheduler.sv
// Row sequencer feeding one PE's filter/ifmap buffers from a 1-cycle-latency memory.
// Define FILTER_REUSE_EN to fetch filter words for row 0 only.
module pe_row_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 6,
  parameter int ROWS_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic [ROWS_WIDTH-1:0]   cfg_num_rows,
  input  logic [LEN_WIDTH-1:0]    cfg_filter_len,
  input  logic [LEN_WIDTH-1:0]    cfg_ifmap_len,
  input  logic [ADDR_WIDTH-1:0]   cfg_filter_base,
  input  logic [ADDR_WIDTH-1:0]   cfg_ifmap_base,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data,
  output logic                    flb_write_en,
  output logic [DATA_WIDTH-1:0]   flb_data,
  input  logic                    flb_full,
  output logic                    ifb_write_en,
  output logic [DATA_WIDTH+1:0]   ifb_data,
  input  logic                    ifb_full,
  output logic                    pe_start,
  input  logic                    pe_done,
  output logic                    busy,
  output logic [ROWS_WIDTH-1:0]   row_idx,
  output logic                    done
);

  typedef enum logic [2:0] {
    IDLE,
    START_PE,
    LOAD_FILT,
    LOAD_IFMAP,
    WAIT_PE,
    FINISH
  } state_t;

  state_t state_q, state_d;

  logic [ROWS_WIDTH-1:0] num_rows_q;
  logic [ROWS_WIDTH-1:0] row_q;
  logic [LEN_WIDTH-1:0]  filt_len_q;
  logic [LEN_WIDTH-1:0]  ifm_len_q;
  logic [LEN_WIDTH-1:0]  issued_q;
  logic [LEN_WIDTH-1:0]  written_q;
  logic [ADDR_WIDTH-1:0] filt_ptr_q;
  logic [ADDR_WIDTH-1:0] ifm_ptr_q;
  logic                  pend_q;
  logic                  skid_vld_q;
  logic [DATA_WIDTH-1:0] skid_q;

  logic                  in_filt;
  logic                  in_ifm;
  logic                  loading;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic                  tgt_full;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  last_wr;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  cfg_go;
  logic                  need_filt;
  logic                  last_row;
  logic                  to_skid;

  assign in_filt  = (state_q == LOAD_FILT);
  assign in_ifm   = (state_q == LOAD_IFMAP);
  assign loading  = in_filt | in_ifm;
  assign cur_len  = in_filt ? filt_len_q : ifm_len_q;
  assign tgt_full = in_filt ? flb_full : ifb_full;
  assign cfg_go   = (state_q == IDLE) && cfg_start;
  assign last_row = (row_q == num_rows_q - ROWS_WIDTH'(1));

  // A read is only issued when its data can land in the buffer or the skid.
  assign rd_fire  = loading && (issued_q != cur_len)
                 && !tgt_full && !skid_vld_q;
  assign wr_fire  = loading && !tgt_full && (skid_vld_q || pend_q);
  assign wr_word  = skid_vld_q ? skid_q : mem_rd_data;
  assign last_wr  = wr_fire
                 && (written_q == cur_len - LEN_WIDTH'(1));
  assign to_skid  = pend_q && (tgt_full || skid_vld_q);

`ifdef FILTER_REUSE_EN
  assign need_filt = (row_q == '0);
`else
  assign need_filt = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = (cfg_num_rows == '0) ? FINISH : START_PE;
        end
      end
      START_PE: begin
        if (need_filt && filt_len_q != '0) begin
          state_d = LOAD_FILT;
        end else if (ifm_len_q != '0) begin
          state_d = LOAD_IFMAP;
        end else begin
          state_d = WAIT_PE;
        end
      end
      LOAD_FILT: begin
        if (last_wr) begin
          state_d = (ifm_len_q != '0) ? LOAD_IFMAP : WAIT_PE;
        end
      end
      LOAD_IFMAP: begin
        if (last_wr) begin
          state_d = WAIT_PE;
        end
      end
      WAIT_PE: begin
        if (pe_done) begin
          state_d = last_row ? FINISH : START_PE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_rows_q <= '0;
      row_q      <= '0;
      filt_len_q <= '0;
      ifm_len_q  <= '0;
      issued_q   <= '0;
      written_q  <= '0;
      filt_ptr_q <= '0;
      ifm_ptr_q  <= '0;
      pend_q     <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      pend_q <= rd_fire;
      if (cfg_go) begin
        num_rows_q <= cfg_num_rows;
        filt_len_q <= cfg_filter_len;
        ifm_len_q  <= cfg_ifmap_len;
        filt_ptr_q <= cfg_filter_base;
        ifm_ptr_q  <= cfg_ifmap_base;
        row_q      <= '0;
        issued_q   <= '0;
        written_q  <= '0;
        skid_vld_q <= 1'b0;
      end
      if (rd_fire) begin
        issued_q <= issued_q + LEN_WIDTH'(1);
        if (in_filt) begin
          filt_ptr_q <= filt_ptr_q + ADDR_WIDTH'(1);
        end else begin
          ifm_ptr_q <= ifm_ptr_q + ADDR_WIDTH'(1);
        end
      end
      if (wr_fire) begin
        written_q <= written_q + LEN_WIDTH'(1);
      end
      if (to_skid) begin
        skid_vld_q <= 1'b1;
        skid_q     <= mem_rd_data;
      end else if (wr_fire && skid_vld_q) begin
        skid_vld_q <= 1'b0;
      end
      if (last_wr) begin
        issued_q  <= '0;
        written_q <= '0;
      end
      if (state_q == WAIT_PE && pe_done && !last_row) begin
        row_q <= row_q + ROWS_WIDTH'(1);
      end
    end
  end

  assign mem_rd_en    = rd_fire;
  assign mem_addr     = !rd_fire ? '0
                      : (in_filt ? filt_ptr_q : ifm_ptr_q);
  assign flb_write_en = wr_fire && in_filt;
  assign flb_data     = flb_write_en ? wr_word : '0;
  assign ifb_write_en = wr_fire && in_ifm;
  assign ifb_data     = !ifb_write_en ? '0
                      : {written_q == '0,
                         written_q == ifm_len_q - LEN_WIDTH'(1),
                         wr_word};
  assign pe_start     = (state_q == START_PE);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FINISH);
  assign row_idx      = row_q;

endmodule

// File: tb/tb_pe_row_scheduler.sv
// Bench for pe_row_scheduler: random memory, random back-pressure and a queue model
// of the expected read addresses, buffer writes and PE start sequence.
module tb_pe_row_scheduler;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int LW = 6;
  localparam int RW = 4;

`ifdef FILTER_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [RW-1:0] cfg_num_rows;
  logic [LW-1:0] cfg_filter_len;
  logic [LW-1:0] cfg_ifmap_len;
  logic [AW-1:0] cfg_filter_base;
  logic [AW-1:0] cfg_ifmap_base;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          flb_write_en;
  logic [DW-1:0] flb_data;
  logic          flb_full;
  logic          ifb_write_en;
  logic [DW+1:0] ifb_data;
  logic          ifb_full;
  logic          pe_start;
  logic          pe_done;
  logic          busy;
  logic [RW-1:0] row_idx;
  logic          done;

  always #5 clk = ~clk;

  pe_row_scheduler #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .LEN_WIDTH(LW), .ROWS_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start),
    .cfg_num_rows(cfg_num_rows),
    .cfg_filter_len(cfg_filter_len),
    .cfg_ifmap_len(cfg_ifmap_len),
    .cfg_filter_base(cfg_filter_base),
    .cfg_ifmap_base(cfg_ifmap_base),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
    .flb_write_en(flb_write_en), .flb_data(flb_data),
    .flb_full(flb_full),
    .ifb_write_en(ifb_write_en), .ifb_data(ifb_data),
    .ifb_full(ifb_full),
    .pe_start(pe_start), .pe_done(pe_done),
    .busy(busy), .row_idx(row_idx), .done(done)
  );

  logic [DW-1:0] mem [256];

  // Source memory: 1-cycle latency, garbage when not read.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    else           mem_rd_data <= DW'($urandom);
  end

  int n_pass  = 0;
  int n_total = 0;

  int            exp_addr[$];
  int            obs_addr[$];
  logic [DW-1:0] exp_f[$];
  logic [DW-1:0] obs_f[$];
  logic [DW+1:0] exp_i[$];
  logic [DW+1:0] obs_i[$];
  int            obs_rows[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic run_pass(input int rows, input int fl,
                          input int il, input int fb,
                          input int ib, input int frate,
                          input bit poke, input bit hold,
                          input bit rst_mid);
    int cum[$];
    int tot = 0;
    int starts = 0;
    int a;
    bit waiting = 0;
    int pe_row = 0;
    int dly = 0;
    int hold_cnt = 0;
    bit held = 0;
    int done_cnt = 0;
    int busy_err = 0;
    int both_cnt = 0;
    bit got_done = 0;
    bit timeout = 1;
    exp_addr.delete(); obs_addr.delete();
    exp_f.delete(); obs_f.delete();
    exp_i.delete(); obs_i.delete();
    obs_rows.delete();
    for (int r = 0; r < rows; r++) begin
      if (!REUSE || r == 0) begin
        for (int i = 0; i < fl; i++) begin
          a = (fb + r * fl + i) % 256;
          exp_addr.push_back(a);
          exp_f.push_back(mem[a]);
          tot++;
        end
      end
      for (int i = 0; i < il; i++) begin
        a = (ib + r * il + i) % 256;
        exp_addr.push_back(a);
        exp_i.push_back({i == 0, i == il - 1, mem[a]});
        tot++;
      end
      cum.push_back(tot);
    end

    @(negedge clk);
    cfg_num_rows    = RW'(rows);
    cfg_filter_len  = LW'(fl);
    cfg_ifmap_len   = LW'(il);
    cfg_filter_base = AW'(fb);
    cfg_ifmap_base  = AW'(ib);
    cfg_start       = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      cfg_start = 1'b0;
      pe_done   = 1'b0;
      if (poke && cyc == 2 && !got_done) begin
        cfg_start       = 1'b1;
        cfg_num_rows    = 4'd9;
        cfg_filter_len  = 6'd7;
        cfg_ifmap_len   = 6'd5;
        cfg_filter_base = 8'hc0;
        cfg_ifmap_base  = 8'he0;
      end
      flb_full = (frate > 0) && (int'($urandom_range(99)) < frate);
      ifb_full = (frate > 0) && (int'($urandom_range(99)) < frate);
      if (hold_cnt > 0) begin
        ifb_full = 1'b1;
        hold_cnt--;
      end
      if (waiting && (obs_f.size() + obs_i.size()) >= cum[pe_row]) begin
        if (dly == 0) begin
          pe_done = 1'b1;
          waiting = 0;
        end else begin
          dly--;
        end
      end
      #1;
      if (got_done) begin
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        timeout = 0;
        break;
      end
      if (mem_rd_en) obs_addr.push_back(int'(mem_addr));
      if (flb_write_en) obs_f.push_back(flb_data);
      if (ifb_write_en) obs_i.push_back(ifb_data);
      if (flb_write_en && ifb_write_en) both_cnt++;
      if (busy !== 1'b1) busy_err++;
      if (pe_start) begin
        obs_rows.push_back(int'(row_idx));
        if (starts < rows) begin
          waiting = 1;
          pe_row  = starts;
          dly     = $urandom_range(2);
        end
        starts++;
      end
      if (done) begin
        done_cnt++;
        got_done = 1;
      end
      if (hold && !held && ifb_write_en) begin
        held     = 1;
        hold_cnt = 3;
      end
      if (rst_mid && flb_write_en) begin
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_ctl", {mem_rd_en, flb_write_en, ifb_write_en,
                        pe_start, busy, done, row_idx}, 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_flb", 32'(flb_data), 0);
        chk("rst_ifb", 32'(ifb_data), 0);
        flb_full = 1'b0;
        ifb_full = 1'b0;
        rst = 1'b1;
        return;
      end
    end

    chk("pass_timeout", timeout, 0);
    chk("rd_count", obs_addr.size(), exp_addr.size());
    for (int i = 0; i < min2(obs_addr.size(), exp_addr.size()); i++)
      chk($sformatf("rd_addr[%0d]", i), obs_addr[i], exp_addr[i]);
    chk("flb_count", obs_f.size(), exp_f.size());
    for (int i = 0; i < min2(obs_f.size(), exp_f.size()); i++)
      chk($sformatf("flb_data[%0d]", i), 32'(obs_f[i]), 32'(exp_f[i]));
    chk("ifb_count", obs_i.size(), exp_i.size());
    for (int i = 0; i < min2(obs_i.size(), exp_i.size()); i++)
      chk($sformatf("ifb_data[%0d]", i), 32'(obs_i[i]), 32'(exp_i[i]));
    chk("pe_start_count", obs_rows.size(), rows);
    for (int i = 0; i < min2(obs_rows.size(), rows); i++)
      chk($sformatf("row_idx_at_start[%0d]", i), obs_rows[i], i);
    chk("done_count", done_cnt, 1);
    chk("busy_during_pass", busy_err, 0);
    chk("flb_ifb_exclusive", both_cnt, 0);
    chk("row_idx_hold", 32'(row_idx), (rows > 0) ? rows - 1 : 0);
  endtask

  initial begin
    rst = 1'b0;
    cfg_start = 1'b0;
    cfg_num_rows = '0;
    cfg_filter_len = '0;
    cfg_ifmap_len = '0;
    cfg_filter_base = '0;
    cfg_ifmap_base = '0;
    flb_full = 1'b0;
    ifb_full = 1'b0;
    pe_done = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);

    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctl", {mem_rd_en, flb_write_en, ifb_write_en,
                      pe_start, busy, done, row_idx}, 0);
    chk("reset_data", {flb_data, 8'h0, mem_addr}, 0);
    chk("reset_ifb", 32'(ifb_data), 0);
    @(negedge clk);
    rst = 1'b1;

    // Stray pe_done in idle does nothing.
    @(negedge clk);
    pe_done = 1'b1;
    @(negedge clk);
    pe_done = 1'b0;
    #1;
    chk("idle_pe_done_busy", busy, 0);
    chk("idle_pe_done_row", 32'(row_idx), 0);

    run_pass(1, 4, 2, 8'h00, 8'h10, 0, 0, 0, 0);
    run_pass(3, 2, 3, 8'h00, 8'h10, 0, 0, 0, 0);
    run_pass(2, 3, 6, 8'h20, 8'h40, 0, 0, 1, 0);
    run_pass(2, 0, 1, 8'h30, 8'h50, 0, 0, 0, 0);
    run_pass(2, 4, 3, 8'h00, 8'h10, 0, 0, 0, 1);
    run_pass(2, 3, 2, 8'h00, 8'h10, 0, 0, 0, 0);
    run_pass(2, 4, 3, 8'h60, 8'h80, 0, 1, 0, 0);
    run_pass(0, 4, 3, 8'h00, 8'h10, 0, 0, 0, 0);
    run_pass(3, 5, 4, 8'hfc, 8'hfa, 30, 0, 1, 0);

    for (int k = 0; k < 8; k++) begin
      run_pass($urandom_range(1, 4), $urandom_range(0, 6),
               $urandom_range(0, 6), $urandom_range(255),
               $urandom_range(255), 30, k[0], k[1], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
